// File: rtl/bit_index_encoder_if.sv
// Purpose : stream bundle for bit_index_encoder (vector in, index stream out, status).
// Ports   : vec_valid/vec_ready/vec_data in; idx_valid/idx_ready/idx_data/idx_last out;
//           vec_count/zero_vec status. slave = encoder view, master = producer/consumer view.
`timescale 1ns/1ps
interface bit_index_encoder_if #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
);
    // Vector input stream
    logic             vec_valid;
    logic             vec_ready;
    logic [WIDTH-1:0] vec_data;

    // Index output stream
    logic             idx_valid;
    logic             idx_ready;
    logic [IDX_W-1:0] idx_data;
    logic             idx_last;

    // Status
    logic [CNT_W-1:0] vec_count;
    logic             zero_vec;

    // Encoder side
    modport slave (
        input  vec_valid,
        input  vec_data,
        output vec_ready,
        output idx_valid,
        output idx_data,
        output idx_last,
        input  idx_ready,
        output vec_count,
        output zero_vec
    );

    // Environment side: drives vectors, consumes indices
    modport master (
        output vec_valid,
        output vec_data,
        input  vec_ready,
        input  idx_valid,
        input  idx_data,
        input  idx_last,
        output idx_ready,
        input  vec_count,
        input  zero_vec
    );
endinterface

// File: rtl/bit_index_encoder.sv
// Purpose : serialises the indices of all set bits of a WIDTH-bit vector, lowest first.
// Latency : vector accepted at edge N -> first index valid in cycle N+1; one index per cycle.
// Backpr. : idx_valid never drops while an index is pending; idx_data/idx_last held until
//           idx_ready. vec_ready only in IDLE, so a new vector waits for the final handshake.
// Ports   : clock, reset_n (async active-low), bus (bit_index_encoder_if.slave).
//           Interface parameters must match WIDTH/IDX_W/CNT_W of this module.
`timescale 1ns/1ps
module bit_index_encoder #(
    parameter int WIDTH = 16,   // 2 <= WIDTH <= 2**IDX_W
    parameter int IDX_W = 4,
    parameter int CNT_W = 5     // must be able to hold the value WIDTH
) (
    input  logic               clock,
    input  logic               reset_n,
    bit_index_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;   // bits still to be emitted
    logic [CNT_W-1:0] count_q, count_d;     // popcount of last accepted vector

    logic [WIDTH-1:0] low_onehot;           // lowest set bit of shadow, isolated
    logic [IDX_W-1:0] low_idx;              // its index
    logic             single_bit;           // shadow holds exactly one set bit

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign low_onehot = shadow_q & (~shadow_q + WIDTH'(1));

    // Exactly one bit set: non-zero, and nothing remains once the lowest bit is removed.
    assign single_bit = (shadow_q != '0) && ((shadow_q & ~low_onehot) == '0);

    // Priority encoder: scanning from the top down leaves the lowest set index last.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (shadow_q[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (bus.vec_valid) begin
                    shadow_d = bus.vec_data;
                    count_d  = popcount(bus.vec_data);
                    state_d  = (bus.vec_data != '0) ? EMIT : ZERO;
                end
            end
            EMIT: begin
                if (bus.idx_ready) begin
                    shadow_d = shadow_q & ~low_onehot;
                    if (single_bit) begin
                        state_d = IDLE;
                    end
                end
            end
            ZERO: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                shadow_d = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

    // Outputs are pure functions of registered state, so reset takes effect at once.
    // Index outputs are gated so they read zero outside EMIT.
    always_comb begin
        bus.vec_ready = (state_q == IDLE);
        bus.idx_valid = (state_q == EMIT);
        bus.idx_data  = (state_q == EMIT) ? low_idx : '0;
        bus.idx_last  = (state_q == EMIT) && single_bit;
        bus.vec_count = count_q;
        bus.zero_vec  = (state_q == ZERO);
    end

    // Stream invariants
    a_idx_hold : assert property (
        @(posedge clock) disable iff (!reset_n)
        (bus.idx_valid && !bus.idx_ready) |=>
            (bus.idx_valid && $stable(bus.idx_data) && $stable(bus.idx_last))
    );

    a_emit_nonzero : assert property (
        @(posedge clock) disable iff (!reset_n)
        (state_q == EMIT) |-> (shadow_q != '0)
    );

endmodule

// File: tb/tb_bit_index_encoder.sv
// Purpose : self-checking bench for bit_index_encoder (directed vectors plus random sweep).
// Latency : inputs driven and outputs sampled 1 ns after each rising clock edge.
// Backpr. : exercises idx_ready held high, toggling and random.
`timescale 1ns/1ps
module tb_bit_index_encoder;

    localparam int WIDTH = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 5;

    logic clock;
    logic reset_n;

    int n_checks = 0;
    int n_errors = 0;

    bit_index_encoder_if #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    bit_index_encoder #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_count);
        check({tag, " vec_ready"}, 32'(bus.vec_ready), 1);
        check({tag, " idx_valid"}, 32'(bus.idx_valid), 0);
        check({tag, " zero_vec"},  32'(bus.zero_vec),  0);
        check({tag, " vec_count"}, 32'(bus.vec_count), exp_count);
    endtask

    // Offer vector v and drain it. mode: 0 = idx_ready always 1,
    // 1 = idx_ready low one cycle then high per index, 2 = random idx_ready.
    task automatic run_vec(input logic [15:0] v, input int mode);
        int  pc;
        int  n;
        int  cyc;
        bit  rdy;
        pc  = 0;
        for (int b = 0; b < WIDTH; b++) pc += int'(v[b]);
        cyc = 0;
        while (!bus.vec_ready && cyc < 50) begin
            step();
            cyc++;
        end
        check("vec_ready before accept", 32'(bus.vec_ready), 1);
        bus.idx_ready = (mode == 0);
        bus.vec_valid = 1'b1;
        bus.vec_data  = v;
        step();
        bus.vec_valid = 1'b0;
        bus.vec_data  = 16'($urandom);
        check("vec_count after accept", 32'(bus.vec_count), 32'(pc));
        if (v == 16'h0000) begin
            check("zero_vec pulse",        32'(bus.zero_vec),  1);
            check("idx_valid in zero",     32'(bus.idx_valid), 0);
            check("vec_ready in zero",     32'(bus.vec_ready), 0);
            step();
            check_idle("after zero", 0);
        end else begin
            n = 0;
            for (int b = 0; b < WIDTH; b++) begin
                if (v[b]) begin
                    n++;
                    cyc = 0;
                    do begin
                        case (mode)
                            0:       rdy = 1'b1;
                            1:       rdy = (cyc % 2 == 1);
                            default: rdy = (cyc >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                        endcase
                        bus.idx_ready = rdy;
                        check("idx_valid", 32'(bus.idx_valid), 1);
                        check("vec_ready in emit", 32'(bus.vec_ready), 0);
                        check("idx_data",  32'(bus.idx_data),  32'(b));
                        check("idx_last",  32'(bus.idx_last),  32'(n == pc));
                        step();
                        cyc++;
                    end while (!rdy);
                end
            end
            bus.idx_ready = 1'b0;
            check_idle("after drain", 32'(pc));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] v;
        int          sel;

        bus.vec_valid = 1'b0;
        bus.vec_data  = '0;
        bus.idx_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (3) step();

        // Reset values
        check("reset vec_ready", 32'(bus.vec_ready), 1);
        check("reset idx_valid", 32'(bus.idx_valid), 0);
        check("reset idx_data",  32'(bus.idx_data),  0);
        check("reset idx_last",  32'(bus.idx_last),  0);
        check("reset vec_count", 32'(bus.vec_count), 0);
        check("reset zero_vec",  32'(bus.zero_vec),  0);
        reset_n = 1'b1;
        step();

        // Zero vector, sparse vector with idx_ready already high, all-ones under toggling ready
        run_vec(16'h0000, 0);
        run_vec(16'h8421, 0);
        run_vec(16'hFFFF, 1);
        run_vec(16'h8000, 0);
        run_vec(16'h0001, 1);

        // Vector offered during EMIT is not captured until after the final handshake
        run_vec(16'h0008, 2);   // leaves block idle, vec_count = 1
        bus.vec_valid = 1'b1;
        bus.vec_data  = 16'h0008;
        step();
        bus.vec_data  = 16'h0003;
        bus.idx_ready = 1'b0;
        check("t4 idx_data",      32'(bus.idx_data),  3);
        check("t4 vec_ready",     32'(bus.vec_ready), 0);
        step();
        check("t4 hold idx_data", 32'(bus.idx_data),  3);
        check("t4 hold idx_last", 32'(bus.idx_last),  1);
        check("t4 hold vec_count", 32'(bus.vec_count), 1);
        bus.idx_ready = 1'b1;
        step();
        check("t4 idle after hs", 32'(bus.vec_ready), 1);
        check("t4 no idx in idle", 32'(bus.idx_valid), 0);
        step();
        bus.vec_valid = 1'b0;
        check("t4 second count",  32'(bus.vec_count), 2);
        check("t4 second idx0",   32'(bus.idx_data),  0);
        check("t4 second last0",  32'(bus.idx_last),  0);
        step();
        check("t4 second idx1",   32'(bus.idx_data),  1);
        check("t4 second last1",  32'(bus.idx_last),  1);
        step();
        bus.idx_ready = 1'b0;
        check_idle("t4 end", 2);

        // Reset in the middle of EMIT discards pending indices
        bus.idx_ready = 1'b1;
        bus.vec_valid = 1'b1;
        bus.vec_data  = 16'h00F0;
        step();
        bus.vec_valid = 1'b0;
        check("t5 first idx",     32'(bus.idx_data),  4);
        step();
        check("t5 second idx",    32'(bus.idx_data),  5);
        reset_n = 1'b0;
        #1;
        check("t5 rst idx_valid", 32'(bus.idx_valid), 0);
        check("t5 rst vec_ready", 32'(bus.vec_ready), 1);
        check("t5 rst idx_data",  32'(bus.idx_data),  0);
        check("t5 rst vec_count", 32'(bus.vec_count), 0);
        check("t5 rst zero_vec",  32'(bus.zero_vec),  0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("t5 post reset", 0);
        end
        bus.idx_ready = 1'b0;

        // Random sweep against the reference expectations built in run_vec
        for (int t = 0; t < 1000; t++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       v = 16'h0000;
                1:       v = 16'(1 << $urandom_range(0, 15));
                2:       v = 16'hFFFF;
                default: v = 16'($urandom);
            endcase
            run_vec(v, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
